// File: rtl/superh16_pkg.sv
// Shared types and sizing constants for the SuperH16 instruction-fetch path.
package superh16_pkg;

  localparam int ICACHE_SETS       = 64;
  localparam int ICACHE_LINE_BYTES = 64;
  localparam int ICACHE_BEATS      = 4;

  typedef enum logic [1:0] {
    IC_IDLE,
    IC_MISS_REQ,
    IC_REFILL
  } icache_state_t;

endpackage

// File: rtl/superh16_icache_refill_buf.sv
// Refill assembly buffer: collects BEATS beats of a line and pulses line_done_o
// on the final beat, presenting the complete line (final beat merged in) that
// same cycle.
module superh16_icache_refill_buf
  import superh16_pkg::*;
#(
  parameter int BEAT_BITS = 128,
  parameter int BEATS     = ICACHE_BEATS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       beat_valid_i,
  input  logic [BEAT_BITS-1:0]       beat_data_i,
  output logic                       line_done_o,
  output logic [BEATS*BEAT_BITS-1:0] line_o
);

  localparam int CNT_W = $clog2(BEATS);

  logic [CNT_W-1:0]           cnt_q;
  logic [BEATS*BEAT_BITS-1:0] line_q;

  assign line_done_o = beat_valid_i && (cnt_q == CNT_W'(BEATS - 1));

  // Current beat overlays its slot so the install sees the whole line.
  always_comb begin
    line_o = line_q;
    line_o[cnt_q*BEAT_BITS +: BEAT_BITS] = beat_data_i;
  end

  // Store each accepted beat in its slot; the counter wraps to 0 on the last.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else if (beat_valid_i) begin
      line_q[cnt_q*BEAT_BITS +: BEAT_BITS] <= beat_data_i;
      cnt_q                                <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/superh16_icache_ctrl.sv
// Direct-mapped L1 instruction cache controller: one-cycle hit/miss response
// to fetch, single outstanding line refill over a 4-beat burst.
module superh16_icache_ctrl
  import superh16_pkg::*;
#(
  parameter int VADDR_WIDTH = 64,
  parameter int NUM_SETS    = ICACHE_SETS,
  parameter int LINE_BYTES  = ICACHE_LINE_BYTES,
  parameter int BEAT_BITS   = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     icache_req,
  input  logic [VADDR_WIDTH-1:0]   icache_addr,
  output logic                     icache_ack,
  output logic [LINE_BYTES*8-1:0]  icache_data,
  output logic                     icache_miss,
  input  logic                     flush,
  input  logic                     invalidate_all,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [VADDR_WIDTH-1:0]   mem_req_addr,
  input  logic                     mem_resp_valid,
  input  logic [BEAT_BITS-1:0]     mem_resp_data,
  input  logic                     mem_resp_last
);

  localparam int OFF_W     = 6;
  localparam int IDX_W     = $clog2(NUM_SETS);
  localparam int TAG_W     = VADDR_WIDTH - OFF_W - IDX_W;
  localparam int LINE_BITS = LINE_BYTES * 8;
  localparam int BEATS     = LINE_BITS / BEAT_BITS;

  icache_state_t state_q, state_d;

  logic [LINE_BITS-1:0]   data_mem [NUM_SETS];
  logic [TAG_W-1:0]       tag_mem  [NUM_SETS];
  logic [NUM_SETS-1:0]    valid_q;

  logic                   ack_q, miss_q;
  logic [LINE_BITS-1:0]   data_q;
  logic [VADDR_WIDTH-1:0] miss_addr_q;
  logic                   kill_q, kill_d;

  logic [IDX_W-1:0]       req_idx, fill_idx;
  logic [TAG_W-1:0]       req_tag, fill_tag;
  logic                   hit, lookup_hit, lookup_miss;
  logic                   beat_valid, line_done, install, flush_drop;
  logic [LINE_BITS-1:0]   fill_line;

  assign req_idx  = icache_addr[OFF_W +: IDX_W];
  assign req_tag  = icache_addr[VADDR_WIDTH-1 -: TAG_W];
  assign fill_idx = miss_addr_q[OFF_W +: IDX_W];
  assign fill_tag = miss_addr_q[VADDR_WIDTH-1 -: TAG_W];

  // A same-cycle invalidate_all already counts as clearing the line.
  assign hit         = valid_q[req_idx] && (tag_mem[req_idx] == req_tag) && !invalidate_all;
  assign lookup_hit  = icache_req && (state_q == IC_IDLE) && hit;
  assign lookup_miss = icache_req && (state_q == IC_IDLE) && !hit;
  assign flush_drop  = (state_q == IC_MISS_REQ) && flush && !mem_req_ready;
  assign beat_valid  = (state_q == IC_REFILL) && mem_resp_valid;
  assign install     = line_done && !kill_q && !invalidate_all;

  superh16_icache_refill_buf #(
    .BEAT_BITS (BEAT_BITS),
    .BEATS     (BEATS)
  ) u_refill_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .beat_valid_i (beat_valid),
    .beat_data_i  (mem_resp_data),
    .line_done_o  (line_done),
    .line_o       (fill_line)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IC_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: a ready handshake outranks a coincident flush.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IC_IDLE:     if (lookup_miss)   state_d = IC_MISS_REQ;
      IC_MISS_REQ: if (mem_req_ready) state_d = IC_REFILL;
                   else if (flush)    state_d = IC_IDLE;
      IC_REFILL:   if (line_done)     state_d = IC_IDLE;
      default:                        state_d = IC_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    mem_req_valid = (state_q == IC_MISS_REQ);
  end

  // Kill flag: an invalidate while a refill is in flight suppresses its install.
  always_comb begin
    kill_d = kill_q;
    if (invalidate_all && (state_q != IC_IDLE)) kill_d = 1'b1;
    if (line_done || flush_drop)                kill_d = 1'b0;
  end

  // Miss address latch and kill flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_addr_q <= '0;
      kill_q      <= 1'b0;
    end else begin
      kill_q <= kill_d;
      if (lookup_miss) miss_addr_q <= {icache_addr[VADDR_WIDTH-1:OFF_W], OFF_W'(0)};
    end
  end

  // Valid bits: bulk clear beats install.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              valid_q <= '0;
    else if (invalidate_all) valid_q <= '0;
    else if (install)        valid_q[fill_idx] <= 1'b1;
  end

  // Data and tag arrays.
  // NOTE: the arrays carry no reset; a line is unreadable until its valid
  // bit is set, so their power-up contents never matter.
  always_ff @(posedge clk) begin
    if (install) begin
      data_mem[fill_idx] <= fill_line;
      tag_mem[fill_idx]  <= fill_tag;
    end
  end

  // One-cycle lookup response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q  <= 1'b0;
      miss_q <= 1'b0;
      data_q <= '0;
    end else begin
      ack_q  <= lookup_hit;
      miss_q <= icache_req && !lookup_hit;
      if (lookup_hit) data_q <= data_mem[req_idx];
    end
  end

  assign icache_ack   = ack_q;
  assign icache_miss  = miss_q;
  assign icache_data  = data_q;
  assign mem_req_addr = miss_addr_q;

  // The beat counter governs install; the last marker is only cross-checked.
  last_beat_marker_a: assert property (@(posedge clk) disable iff (!rst_n)
    beat_valid |-> (mem_resp_last == line_done));

  logic unused_ok;
  assign unused_ok = ^{icache_addr[OFF_W-1:0], mem_resp_last};

endmodule

// File: tb/tb_superh16_icache_ctrl.sv
// Scoreboard bench for superh16_icache_ctrl: stimulus pushes expected lookup
// responses, an independent monitor pops and compares them.
`timescale 1ns/1ps
module tb_superh16_icache_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         icache_req;
  logic [63:0]  icache_addr;
  logic         icache_ack;
  logic [511:0] icache_data;
  logic         icache_miss;
  logic         flush;
  logic         invalidate_all;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [63:0]  mem_req_addr;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic         mem_resp_last;

  superh16_icache_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .icache_req     (icache_req),
    .icache_addr    (icache_addr),
    .icache_ack     (icache_ack),
    .icache_data    (icache_data),
    .icache_miss    (icache_miss),
    .flush          (flush),
    .invalidate_all (invalidate_all),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_last  (mem_resp_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         ack;
    logic [511:0] data;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic pend   = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference beat pattern and the line it assembles to (beat 0 = bytes 0..15).
  function automatic logic [127:0] beat_of(input logic [63:0] a, input int k);
    return {a[31:0], 24'hC0FFEE, 8'(k), ~a[31:0], 32'hDEAD_0000 | 32'(k)};
  endfunction

  function automatic logic [511:0] line_of(input logic [63:0] a);
    return {beat_of(a, 3), beat_of(a, 2), beat_of(a, 1), beat_of(a, 0)};
  endfunction

  // Monitor: a request sampled at an edge must be answered by the next negedge.
  always @(posedge clk) pend <= rst_n && icache_req;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (pend) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: response with no expectation ack=%0b miss=%0b", icache_ack, icache_miss);
        end else begin
          e = sb.pop_front();
          check({e.name, "_ack"}, 512'(icache_ack), 512'(e.ack));
          check({e.name, "_miss"}, 512'(icache_miss), 512'(!e.ack));
          if (e.ack) check({e.name, "_data"}, icache_data, e.data);
        end
      end else begin
        check("idle_ack", 512'(icache_ack), 512'(0));
        check("idle_miss", 512'(icache_miss), 512'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one lookup for the next cycle and record its expected response.
  task automatic issue(input logic [63:0] a, input logic ack, input string name);
    exp_t e;
    tick();
    icache_req  = 1'b1;
    icache_addr = a;
    e.ack  = ack;
    e.data = line_of({a[63:6], 6'd0});
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic nop();
    tick();
    icache_req = 1'b0;
  endtask

  // Called with the DUT in MISS_REQ: handshake, then stream four beats.
  task automatic refill(input logic [63:0] line, input int inv_beat, input logic req_on_install);
    exp_t e;
    check("mreq_valid", 512'(mem_req_valid), 512'(1));
    check("mreq_addr", 512'(mem_req_addr), 512'(line));
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("mreq_valid_after_hs", 512'(mem_req_valid), 512'(0));
    for (int k = 0; k < 4; k++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = beat_of(line, k);
      mem_resp_last  = (k == 3);
      invalidate_all = (k == inv_beat);
      if (k == 3 && req_on_install) begin
        icache_req  = 1'b1;
        icache_addr = line;
        e.ack  = 1'b0;
        e.data = '0;
        e.name = "install_cycle";
        sb.push_back(e);
      end
      tick();
      icache_req = 1'b0;
    end
    mem_resp_valid = 1'b0;
    mem_resp_last  = 1'b0;
    invalidate_all = 1'b0;
  endtask

  task automatic miss_fill(input logic [63:0] line, input string name);
    issue(line, 1'b0, name);
    nop();
    refill(line, -1, 1'b0);
  endtask

  task automatic miss_and_flush(input logic [63:0] a, input string name);
    issue(a, 1'b0, name);
    nop();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check({name, "_flushed"}, 512'(mem_req_valid), 512'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; icache_req = 1'b0; icache_addr = '0; flush = 1'b0;
    invalidate_all = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_resp_data = '0; mem_resp_last = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", 512'(icache_ack), 512'(0));
    check("rst_miss", 512'(icache_miss), 512'(0));
    check("rst_data", icache_data, 512'(0));
    check("rst_mreq_valid", 512'(mem_req_valid), 512'(0));
    check("rst_mreq_addr", 512'(mem_req_addr), 512'(0));
    tick();
    rst_n = 1'b1;

    // Cold miss with a request on the install cycle, then a hit mid-line.
    issue(64'h8000_0000, 1'b0, "cold_miss");
    nop();
    refill(64'h8000_0000, -1, 1'b1);
    issue(64'h8000_0020, 1'b1, "cold_hit");
    nop();

    // Second line, then back-to-back hits.
    miss_fill(64'h8000_0040, "miss_40");
    issue(64'h8000_0000, 1'b1, "b2b_hit0");
    issue(64'h8000_0040, 1'b1, "b2b_hit1");
    nop();

    // Back-pressure: address held while ready is low; lookups meanwhile miss.
    issue(64'h8000_0080, 1'b0, "bp_miss");
    nop();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 512'(mem_req_valid), 512'(1));
      check("bp_addr", 512'(mem_req_addr), 512'(64'h8000_0080));
      issue(64'h8000_0000, 1'b0, "bp_busy");
    end
    nop();
    refill(64'h8000_0080, -1, 1'b0);
    issue(64'h8000_0080, 1'b1, "bp_hit");
    nop();

    // Flush in MISS_REQ drops the request; the line misses again.
    miss_and_flush(64'h8000_00C0, "flush_miss");
    miss_fill(64'h8000_00C0, "flush_remiss");
    issue(64'h8000_00C0, 1'b1, "flush_hit");
    nop();

    // invalidate_all on beat 2 suppresses the install and clears other lines.
    issue(64'h8000_0100, 1'b0, "inv_miss");
    nop();
    refill(64'h8000_0100, 2, 1'b0);
    miss_and_flush(64'h8000_0100, "inv_refetch");
    miss_and_flush(64'h8000_0040, "inv_other");

    // Conflict on set 0.
    miss_fill(64'h8000_0000, "conf_a");
    miss_fill(64'h8000_1000, "conf_b");
    issue(64'h8000_1000, 1'b1, "conf_b_hit");
    nop();
    miss_and_flush(64'h8000_0000, "conf_a_evicted");

    repeat (3) tick();
    check("sb_empty", 512'(sb.size()), 512'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
